// File: rtl/hd_xfer_pkg.sv
// Shared types for the HD block mover: FSM states, direction codes, header offset.
// Used by hd_block_transfer (optional checksum stage selected by CHECKSUM_EN).
package hd_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      HDR,
      XFER,
      CKSUM,
      DONE,
      ERR
   } state_t;

   localparam logic DIR_LOAD = 1'b0;
   localparam logic DIR_SAVE = 1'b1;

   // Payload starts one word after the length header of each block.
   localparam int HDR_OFS = 1;

endpackage

// File: rtl/hd_xfer_addr_gen.sv
// Address generator for the block mover: HD/memory addresses per state and last-word flag.
// The CKSUM address is only reached when the top is built with CHECKSUM_EN.
module hd_xfer_addr_gen
   import hd_xfer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int HD_AW  = 32,
   parameter int MEM_AW = 10
) (
   input  state_t            state,
   input  logic [HD_AW-1:0]  base,
   input  logic [DATA_W-1:0] idx,
   input  logic [DATA_W-1:0] len,
   output logic [HD_AW-1:0]  hd_addr,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              last
);

   // Addresses are held at zero outside the states that access a port.
   always_comb begin
      hd_addr  = '0;
      mem_addr = '0;
      case (state)
         HDR:   hd_addr = base;
         XFER: begin
            hd_addr  = base + HD_AW'(HDR_OFS) + HD_AW'(idx);
            mem_addr = idx[MEM_AW-1:0];
         end
         CKSUM: hd_addr = base + HD_AW'(HDR_OFS) + HD_AW'(len);
         default: ;
      endcase
   end

   assign last = (idx == len - DATA_W'(1));

endmodule

// File: rtl/hd_block_transfer.sv
// HD <-> instruction-memory block mover (LOAD/SAVE) with header-length checking.
// Define CHECKSUM_EN to add a trailing XOR checksum word and a CKSUM state.
module hd_block_transfer
   import hd_xfer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int HD_AW      = 32,
   parameter int MEM_AW     = 10,
   parameter int BLOCK_SIZE = 200,
   parameter int NUM_BLOCKS = 20
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          dir,
   input  logic [$clog2(NUM_BLOCKS)-1:0] block_num,
   input  logic [DATA_W-1:0]             save_len,
   output logic [HD_AW-1:0]              hd_addr,
   input  logic [DATA_W-1:0]             hd_rdata,
   output logic [DATA_W-1:0]             hd_wdata,
   output logic                          hd_we,
   output logic [MEM_AW-1:0]             mem_addr,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic                          mem_we,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [DATA_W-1:0]             word_count
);

   localparam int BN_W = $clog2(NUM_BLOCKS);
`ifdef CHECKSUM_EN
   localparam int MAX_LEN = BLOCK_SIZE - 2;
`else
   localparam int MAX_LEN = BLOCK_SIZE - 1;
`endif

   state_t            state, state_nxt;
   logic              dir_r;
   logic [BN_W-1:0]   blk_r;
   logic [HD_AW-1:0]  base;
   logic [DATA_W-1:0] len;
   logic [DATA_W-1:0] idx;
   logic              last;
`ifdef CHECKSUM_EN
   logic [DATA_W-1:0] cksum;
`endif

   hd_xfer_addr_gen #(
      .DATA_W (DATA_W),
      .HD_AW  (HD_AW),
      .MEM_AW (MEM_AW)
   ) u_addr_gen (
      .state    (state),
      .base     (base),
      .idx      (idx),
      .len      (len),
      .hd_addr  (hd_addr),
      .mem_addr (mem_addr),
      .last     (last)
   );

   // Request parameters are captured once, when start is accepted in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dir_r      <= DIR_LOAD;
         blk_r      <= '0;
         base       <= '0;
         len        <= '0;
         idx        <= '0;
         word_count <= '0;
`ifdef CHECKSUM_EN
         cksum      <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               dir_r      <= dir;
               blk_r      <= block_num;
               base       <= HD_AW'(block_num) * HD_AW'(BLOCK_SIZE);
               len        <= (dir == DIR_SAVE) ? save_len : '0;
               idx        <= '0;
               word_count <= '0;
            end
            HDR: begin
               idx <= '0;
               if (dir_r == DIR_LOAD) len <= hd_rdata;
`ifdef CHECKSUM_EN
               cksum <= '0;
`endif
            end
            XFER: begin
               word_count <= idx + DATA_W'(1);
               if (!last) idx <= idx + DATA_W'(1);
`ifdef CHECKSUM_EN
               cksum <= cksum ^ ((dir_r == DIR_SAVE) ? mem_rdata : hd_rdata);
`endif
            end
            default: ;
         endcase
      end
   end

   // Next state and port strobes; everything defaults to idle values.
   always_comb begin
      state_nxt = state;
      hd_wdata  = '0;
      hd_we     = 1'b0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = CHECK;
         CHECK: begin
            if (({1'b0, blk_r} >= (BN_W+1)'(NUM_BLOCKS)) ||
                ((dir_r == DIR_SAVE) && (len > DATA_W'(MAX_LEN))))
               state_nxt = ERR;
            else
               state_nxt = HDR;
         end
         HDR: begin
            if (dir_r == DIR_LOAD) begin
               if (hd_rdata > DATA_W'(MAX_LEN)) state_nxt = ERR;
               else if (hd_rdata == '0)         state_nxt = DONE;
               else                             state_nxt = XFER;
            end else begin
               hd_wdata  = len;
               hd_we     = 1'b1;
               state_nxt = (len == '0) ? DONE : XFER;
            end
         end
         XFER: begin
            if (dir_r == DIR_LOAD) begin
               mem_we    = 1'b1;
               mem_wdata = hd_rdata;
            end else begin
               hd_we    = 1'b1;
               hd_wdata = mem_rdata;
            end
`ifdef CHECKSUM_EN
            if (last) state_nxt = CKSUM;
`else
            if (last) state_nxt = DONE;
`endif
         end
`ifdef CHECKSUM_EN
         CKSUM: begin
            if (dir_r == DIR_LOAD) begin
               state_nxt = (hd_rdata != cksum) ? ERR : DONE;
            end else begin
               hd_we     = 1'b1;
               hd_wdata  = cksum;
               state_nxt = DONE;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy  = (state == CHECK) || (state == HDR) || (state == XFER) || (state == CKSUM);
   assign done  = (state == DONE);
   assign error = (state == ERR);

endmodule

// File: tb/tb_hd_block_transfer.sv
// Scoreboard bench for hd_block_transfer with a behavioural HD/memory reference model.
// Honours CHECKSUM_EN when the bench and RTL are built with it.
module tb_hd_block_transfer;

   localparam int DATA_W     = 32;
   localparam int HD_AW      = 32;
   localparam int MEM_AW     = 10;
   localparam int BLOCK_SIZE = 200;
   localparam int NUM_BLOCKS = 20;
   localparam int HD_WORDS   = BLOCK_SIZE * NUM_BLOCKS;
   localparam int MEM_WORDS  = 1 << MEM_AW;
`ifdef CHECKSUM_EN
   localparam int MAX_LEN = BLOCK_SIZE - 2;
   localparam int CK_EXTRA = 1;
`else
   localparam int MAX_LEN = BLOCK_SIZE - 1;
   localparam int CK_EXTRA = 0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              dir;
   logic [4:0]        block_num;
   logic [DATA_W-1:0] save_len;
   logic [HD_AW-1:0]  hd_addr;
   logic [DATA_W-1:0] hd_rdata;
   logic [DATA_W-1:0] hd_wdata;
   logic              hd_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              busy, done, error;
   logic [DATA_W-1:0] word_count;

   hd_block_transfer #(
      .DATA_W(DATA_W), .HD_AW(HD_AW), .MEM_AW(MEM_AW),
      .BLOCK_SIZE(BLOCK_SIZE), .NUM_BLOCKS(NUM_BLOCKS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .dir(dir),
      .block_num(block_num), .save_len(save_len),
      .hd_addr(hd_addr), .hd_rdata(hd_rdata), .hd_wdata(hd_wdata), .hd_we(hd_we),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .busy(busy), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Environment memories driven by the DUT, and reference copies updated by the model.
   logic [DATA_W-1:0] hd_arr  [HD_WORDS];
   logic [DATA_W-1:0] mem_arr [MEM_WORDS];
   logic [DATA_W-1:0] ref_hd  [HD_WORDS];
   logic [DATA_W-1:0] ref_mem [MEM_WORDS];

   always_comb hd_rdata  = (hd_addr < HD_AW'(HD_WORDS)) ? hd_arr[hd_addr[11:0]] : '0;
   always_comb mem_rdata = mem_arr[mem_addr];

   always @(posedge clk) begin
      if (hd_we && hd_addr < HD_AW'(HD_WORDS)) hd_arr[hd_addr[11:0]] <= hd_wdata;
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  kind;
      int          cyc;
      logic [31:0] wc;
   } exp_t;

   exp_t exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done/error pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      if (!reset && (done || error)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_response: got done=%0b error=%0b, expected none", done, error);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("resp_kind",   {done, error}, e.kind);
            check_output("resp_cycle",  cyc,           e.cyc);
            check_output("word_count",  word_count,    e.wc);
            check_output("busy_at_end", busy,          1'b0);
         end
      end
   end

   task automatic put_hd(input int a, input logic [31:0] v);
      hd_arr[a] = v;
      ref_hd[a] = v;
   endtask

   task automatic put_mem(input int a, input logic [31:0] v);
      mem_arr[a] = v;
      ref_mem[a] = v;
   endtask

   task automatic compare_arrays(input string tag);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < HD_WORDS; i++)
         if (hd_arr[i] !== ref_hd[i]) begin bad++; if (first < 0) first = i; end
      for (int i = 0; i < MEM_WORDS; i++)
         if (mem_arr[i] !== ref_mem[i]) begin bad++; if (first < 0) first = HD_WORDS + i; end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL %s_contents: %0d words differ from model, first at flat index %0d", tag, bad, first);
      end
   endtask

   // Fill a LOAD block: header, payload and (with checksum) trailing XOR word.
   task automatic setup_load(input int blk, input int len, input bit corrupt);
      int b = blk * BLOCK_SIZE;
      logic [31:0] x = '0;
      logic [31:0] w;
      put_hd(b, len);
      if (len > 0 && len <= MAX_LEN) begin
         for (int i = 0; i < len; i++) begin
            w = $urandom;
            put_hd(b + 1 + i, w);
            x = x ^ w;
         end
         if (CK_EXTRA != 0) put_hd(b + 1 + len, corrupt ? (x ^ 32'h1) : x);
      end
   endtask

   // Drive one request, predict its result from the block rules, and wait for the pulse.
   task automatic apply_stimulus(input logic d, input int blk, input int len_arg, input bit noise);
      exp_t e;
      int b = blk * BLOCK_SIZE;
      int lat;
      int len;
      int n;
      logic [31:0] x = '0;
      e.kind = 2'b10;
      e.wc   = 0;
      if (blk >= NUM_BLOCKS) begin
         e.kind = 2'b01; lat = 2;
      end else if (d == 1'b0) begin
         len = int'(ref_hd[b]);
         if (ref_hd[b] > MAX_LEN) begin
            e.kind = 2'b01; lat = 3;
         end else if (len == 0) begin
            lat = 3;
         end else begin
            for (int i = 0; i < len; i++) begin
               ref_mem[i % MEM_WORDS] = ref_hd[b + 1 + i];
               x = x ^ ref_hd[b + 1 + i];
            end
            e.wc = len;
            lat  = len + 3 + CK_EXTRA;
            if (CK_EXTRA != 0 && ref_hd[b + 1 + len] != x) e.kind = 2'b01;
         end
      end else begin
         if (len_arg > MAX_LEN) begin
            e.kind = 2'b01; lat = 2;
         end else begin
            ref_hd[b] = len_arg;
            for (int i = 0; i < len_arg; i++) begin
               ref_hd[b + 1 + i] = ref_mem[i % MEM_WORDS];
               x = x ^ ref_mem[i % MEM_WORDS];
            end
            lat = len_arg + 3;
            if (CK_EXTRA != 0 && len_arg > 0) begin
               ref_hd[b + 1 + len_arg] = x;
               lat++;
            end
            e.wc = len_arg;
         end
      end

      dir       = d;
      block_num = blk[4:0];
      save_len  = len_arg;
      start     = 1'b1;
      e.cyc     = cyc + lat;
      exp_q.push_back(e);

      @(negedge clk);
      start = noise ? 1'($urandom % 2) : 1'b0;
      check_output("busy_in_check", busy, 1'b1);
      if (noise) begin
         dir       = 1'($urandom % 2);
         block_num = 5'($urandom);
         save_len  = $urandom;
      end
      n = 0;
      while (!(done || error) && n < 400) begin
         @(negedge clk);
         start = noise ? 1'($urandom % 2) : 1'b0;
         n++;
      end
      start = 1'b0;
      if (n >= 400) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: got no done/error in 400 cycles, expected one");
         exp_q.delete();
      end
      @(negedge clk);
      compare_arrays("xfer");
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int blk, len, t0, b;
      logic d;
      reset = 1'b1; start = 1'b0; dir = 1'b0; block_num = '0; save_len = '0;
      for (int i = 0; i < HD_WORDS; i++)  begin hd_arr[i] = '0;  ref_hd[i] = '0;  end
      for (int i = 0; i < MEM_WORDS; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
      repeat (3) @(negedge clk);
      check_output("rst_busy",   busy,       1'b0);
      check_output("rst_done",   done,       1'b0);
      check_output("rst_error",  error,      1'b0);
      check_output("rst_we",     {hd_we, mem_we}, 2'b00);
      check_output("rst_addr",   {hd_addr, 22'(mem_addr)}, 64'h0);
      check_output("rst_wcount", word_count, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] directed: LOAD block 2, header 5");
      put_hd(400, 5);
      for (int i = 0; i < 5; i++) put_hd(401 + i, 32'hA0 + i);
      if (CK_EXTRA != 0) put_hd(406, 32'hA0 ^ 32'hA1 ^ 32'hA2 ^ 32'hA3 ^ 32'hA4);
      apply_stimulus(1'b0, 2, 0, 1'b0);

      $display("[TB] directed: SAVE block 1, length 3");
      put_mem(0, 32'h11); put_mem(1, 32'h22); put_mem(2, 32'h33);
      apply_stimulus(1'b1, 1, 3, 1'b0);

      $display("[TB] directed: LOAD header 0 and header 200");
      setup_load(4, 0, 1'b0);
      apply_stimulus(1'b0, 4, 0, 1'b0);
      setup_load(5, 200, 1'b0);
      apply_stimulus(1'b0, 5, 0, 1'b0);

      $display("[TB] directed: invalid block 20 with start noise, SAVE too long");
      apply_stimulus(1'b0, 20, 0, 1'b1);
      apply_stimulus(1'b1, 3, MAX_LEN + 1, 1'b1);
      apply_stimulus(1'b1, 7, MAX_LEN, 1'b1);

`ifdef CHECKSUM_EN
      $display("[TB] directed: corrupted checksum");
      setup_load(6, 4, 1'b1);
      apply_stimulus(1'b0, 6, 0, 1'b0);
`endif

      $display("[TB] directed: reset during XFER");
      setup_load(3, 5, 1'b0);
      b = 3 * BLOCK_SIZE;
      dir = 1'b0; block_num = 5'd3; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 5) @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("midrst_we",     {hd_we, mem_we}, 2'b00);
      check_output("midrst_flags",  {busy, done, error}, 3'b000);
      check_output("midrst_addr",   {hd_addr, 22'(mem_addr)}, 64'h0);
      check_output("midrst_wcount", word_count, 32'h0);
      ref_mem[0] = ref_hd[b + 1];
      ref_mem[1] = ref_hd[b + 2];
      @(negedge clk);
      reset = 1'b0;
      compare_arrays("partial");
      @(negedge clk);
      apply_stimulus(1'b0, 3, 0, 1'b0);

      $display("[TB] random transfers");
      for (int t = 0; t < 30; t++) begin
         d   = 1'($urandom % 2);
         blk = ($urandom % 8 == 0) ? 20 + int'($urandom % 12) : int'($urandom % 20);
         len = ($urandom % 6 == 0) ? MAX_LEN + 1 + int'($urandom % 3) : int'($urandom % 13);
         if (d == 1'b0 && blk < NUM_BLOCKS) setup_load(blk, len, ($urandom % 4 == 0));
         if (d == 1'b1)
            for (int i = 0; i < len && i <= MAX_LEN; i++) put_mem(i, $urandom);
         apply_stimulus(d, blk, len, 1'b1);
      end

      repeat (5) @(negedge clk);
      check_output("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hd_block_transfer.md
Name: hd_block_transfer

Overview:
Parametrised HD-to-memory block mover for the LabSO processor. On a start pulse it loads a program block from HD into instruction memory (LOAD) or writes a memory region back to an HD block (SAVE). The block length comes from the block header word. It sits between the OS-control path (block number, start, direction) and the HD and instruction-memory ports. It replaces the single-mode, fixed-size manager with a handshake-driven FSM that checks lengths.

Parameters:
DATA_W, 32, data word width of HD and memory
HD_AW, 32, HD address width
MEM_AW, 10, instruction/data memory address width
BLOCK_SIZE, 200, words per HD block (header plus payload)
NUM_BLOCKS, 20, number of HD blocks; block_num >= NUM_BLOCKS is invalid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
dir  in  1  0 = LOAD (HD->mem), 1 = SAVE (mem->HD)
block_num  in  $clog2(NUM_BLOCKS)  target block
save_len  in  DATA_W  payload length for SAVE
hd_addr  out  HD_AW  HD address
hd_rdata  in  DATA_W  HD read data, combinational from hd_addr
hd_wdata  out  DATA_W  HD write data
hd_we  out  1  HD write enable
mem_addr  out  MEM_AW  memory address
mem_rdata  in  DATA_W  memory read data, combinational
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
busy  out  1  high from the cycle after start is accepted until DONE/ERR exits
done  out  1  one-cycle success pulse
error  out  1  one-cycle failure pulse
word_count  out  DATA_W  words moved in last or current transfer

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal base, len and idx registers 0.
- base = block_num * BLOCK_SIZE, computed at HD_AW width and latched with dir/block_num/save_len when start is accepted in IDLE.
- States: IDLE -> CHECK -> HDR -> XFER -> DONE -> IDLE. Any failure goes to ERR -> IDLE.
- CHECK (1 cycle): block_num >= NUM_BLOCKS -> ERR. In SAVE, save_len > BLOCK_SIZE-1 -> ERR.
- HDR, LOAD: hd_addr = base; len <= hd_rdata. len > BLOCK_SIZE-1 -> ERR. len == 0 -> DONE.
- HDR, SAVE: hd_addr = base; hd_wdata = len; hd_we = 1. len == 0 -> DONE.
- XFER: one word per cycle, idx runs 0..len-1; hd_addr = base+1+idx; mem_addr = idx[MEM_AW-1:0].
  - LOAD: mem_we = 1, mem_wdata = hd_rdata.
  - SAVE: hd_we = 1, hd_wdata = mem_rdata.
  - word_count = idx+1 after each write; leave XFER after the write with idx == len-1.
- Latency: start accepted at cycle 0 -> CHECK 1, HDR 2, XFER 3..len+2, done pulse at cycle len+3. For len = 0, done pulses at cycle 3.
- DONE/ERR last one cycle each and assert done/error for that cycle only. busy falls in the same cycle.
- Write enables are 0 in every state except the ones listed above.
- start while busy is ignored. start in the same cycle as the DONE/ERR exit is ignored; a new start is accepted only in IDLE.
- reset mid-transfer: immediate IDLE with write enables low. A partial block is not rolled back.
- len > 2^MEM_AW: mem_addr wraps modulo 2^MEM_AW, no error (length is already bounded by BLOCK_SIZE).

Optional Feature:
CHECKSUM_EN
- Defined: a running XOR of the payload words is kept, and the maximum len becomes BLOCK_SIZE-2.
  - LOAD adds a CKSUM state after XFER: read base+1+len; on mismatch go to ERR instead of DONE.
  - SAVE adds a CKSUM state that writes the XOR to base+1+len.
  - Latency grows by 1 cycle.
- Undefined: no CKSUM state, limit stays BLOCK_SIZE-1, timings exactly as above.

Decomposition:
- Package hd_xfer_pkg holds:
  - state enum (IDLE, CHECK, HDR, XFER, CKSUM, DONE, ERR)
  - DIR_LOAD/DIR_SAVE constants
  - header-offset constant (1)
- One sub-module, hd_xfer_addr_gen: takes base, idx and len; produces hd_addr, mem_addr and the last-word flag. The FSM stays in the top level.

Test Plan:
- LOAD block 2, header 5, payload 0xA0..0xA4 -> mem[0..4] = 0xA0..0xA4; hd_addr 401..405; done at cycle 8; word_count 5.
- SAVE block 1, save_len 3, mem[0..2] = 0x11,0x22,0x33 -> HD[200] = 3, HD[201..203] = 0x11,0x22,0x33; done at cycle 6.
- LOAD with header 0 -> no mem_we; done at cycle 3. LOAD with header 200 -> error pulse at cycle 2+1, no writes.
- block_num = 20 (NUM_BLOCKS) -> error in the cycle after CHECK; start pulses during busy ignored; busy profile checked.
- Reset asserted at XFER idx 2 of a 5-word LOAD -> outputs 0 immediately; next start restarts cleanly from idx 0.
- CHECKSUM_EN: corrupt the checksum word -> error, no done; correct checksum -> done one cycle later than baseline.
